// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared control-bundle layout and ALU operation encodings
package mips_pkg;

    localparam int CTRL_W = 9;

    // Bit positions inside the 9-bit control bundle
    localparam int CTRL_REG_WRITE  = 8;
    localparam int CTRL_MEM_READ   = 7;
    localparam int CTRL_MEM_WRITE  = 6;
    localparam int CTRL_MEM_TO_REG = 5;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_REG_DST    = 3;
    localparam int CTRL_ALU_OP_LSB = 0;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_AND   = 3'd2,
        ALU_OR    = 3'd3,
        ALU_SLT   = 3'd4,
        ALU_RTYPE = 3'd5,
        ALU_LUI   = 3'd6,
        ALU_XOR   = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    reg_dst;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID/EX stage bus: decoded inputs, write-back bus, EX outputs
interface id_ex_stage_if
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] id_rd;
    logic [DATA_W-1:0] id_imm;
    logic [DATA_W-1:0] id_pc4;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_regWrite;
    logic [REG_AW-1:0] wb_writeReg;
    logic [DATA_W-1:0] wb_writeData;
    logic              flush;

    logic [DATA_W-1:0] ex_a;
    logic [DATA_W-1:0] ex_b;
    logic [DATA_W-1:0] ex_imm;
    logic [DATA_W-1:0] ex_pc4;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_rd;
    logic [CTRL_W-1:0] ex_ctrl;
    logic              ex_valid;
    logic              stall;
    logic [15:0]       stall_cnt;

    modport master (
        output data1, data2, id_rs, id_rt, id_rd, id_imm, id_pc4, id_ctrl,
               wb_regWrite, wb_writeReg, wb_writeData, flush,
        input  ex_a, ex_b, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd, ex_ctrl,
               ex_valid, stall, stall_cnt
    );

    modport slave (
        input  data1, data2, id_rs, id_rt, id_rd, id_imm, id_pc4, id_ctrl,
               wb_regWrite, wb_writeReg, wb_writeData, flush,
        output ex_a, ex_b, ex_imm, ex_pc4, ex_rs, ex_rt, ex_rd, ex_ctrl,
               ex_valid, stall, stall_cnt
    );

endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use hazard detection between EX and ID
module hazard_unit #(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_read,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              stall
);

    // A valid load in EX whose destination is read by ID must wait one cycle; r0 never hazards
    always_comb begin
        stall = ex_mem_read && ex_valid && (ex_rt != '0) &&
                ((ex_rt == id_rs) || (ex_rt == id_rt));
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with write-back bypass and bubble insertion
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);

    logic [DATA_W-1:0] ex_a_q;
    logic [DATA_W-1:0] ex_b_q;
    logic [DATA_W-1:0] ex_imm_q;
    logic [DATA_W-1:0] ex_pc4_q;
    logic [REG_AW-1:0] ex_rs_q;
    logic [REG_AW-1:0] ex_rt_q;
    logic [REG_AW-1:0] ex_rd_q;
    ctrl_t             ex_ctrl_q;
    logic              ex_valid_q;
    logic [15:0]       stall_cnt_q;

    logic              stall;
    logic              bubble;
    logic [DATA_W-1:0] a_byp;
    logic [DATA_W-1:0] b_byp;

    hazard_unit #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .ex_mem_read (ex_ctrl_q.mem_read),
        .ex_valid    (ex_valid_q),
        .ex_rt       (ex_rt_q),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .stall       (stall)
    );

    // Register file is written at the same edge we read it, so take the write-back value directly
    always_comb begin
        a_byp = bus.data1;
        b_byp = bus.data2;
        if (bus.wb_regWrite && (bus.wb_writeReg != '0) && (bus.wb_writeReg == bus.id_rs)) begin
            a_byp = bus.wb_writeData;
        end
        if (bus.wb_regWrite && (bus.wb_writeReg != '0) && (bus.wb_writeReg == bus.id_rt)) begin
            b_byp = bus.wb_writeData;
        end
        bubble = bus.flush || stall;
    end

    // EX pipeline registers: flush or stall load an all-zero bubble, otherwise capture ID
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_pc4_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_ctrl_q  <= CTRL_BUBBLE;
            ex_valid_q <= 1'b0;
        end else if (bubble) begin
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_pc4_q   <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_ctrl_q  <= CTRL_BUBBLE;
            ex_valid_q <= 1'b0;
        end else begin
            ex_a_q     <= a_byp;
            ex_b_q     <= b_byp;
            ex_imm_q   <= bus.id_imm;
            ex_pc4_q   <= bus.id_pc4;
            ex_rs_q    <= bus.id_rs;
            ex_rt_q    <= bus.id_rt;
            ex_rd_q    <= bus.id_rd;
            ex_ctrl_q  <= ctrl_t'(bus.id_ctrl);
            ex_valid_q <= 1'b1;
        end
    end

    // Count hazard bubbles only; a flush owns the cycle, and the count saturates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
        end else if (!bus.flush && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign bus.ex_a      = ex_a_q;
    assign bus.ex_b      = ex_b_q;
    assign bus.ex_imm    = ex_imm_q;
    assign bus.ex_pc4    = ex_pc4_q;
    assign bus.ex_rs     = ex_rs_q;
    assign bus.ex_rt     = ex_rt_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.ex_ctrl   = ex_ctrl_q;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;

endmodule
